// File: rtl/fifo_singleclock_fwft_multi_if.sv
// Shared write port and per-channel FWFT read ports
// for the multi-channel single-clock FIFO bank.
interface fifo_singleclock_fwft_multi_if #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 32,
  parameter int CHANNELS = 2
);
  localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]          din;
  logic [CW-1:0]             wr_chan;
  logic                      wr_en;
  logic [CHANNELS-1:0]       full;
  logic [CHANNELS-1:0]       prog_full;
  logic [CHANNELS*WIDTH-1:0] dout;
  logic [CHANNELS-1:0]       rd_en;
  logic [CHANNELS-1:0]       empty;
  logic [CHANNELS*CNTW-1:0]  fill;
  logic [CHANNELS-1:0]       overflow;
  logic [CHANNELS-1:0]       underflow;

  modport master (
    output din, wr_chan, wr_en, rd_en,
    input  full, prog_full, dout, empty,
    input  fill, overflow, underflow
  );

  modport slave (
    input  din, wr_chan, wr_en, rd_en,
    output full, prog_full, dout, empty,
    output fill, overflow, underflow
  );
endinterface

// File: rtl/fifo_singleclock_fwft_multi.sv
// Bank of CHANNELS first-word fall-through FIFOs
// sharing one write port, each with its own read port.
module fifo_singleclock_fwft_multi #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 32,
  parameter int CHANNELS  = 2,
  parameter int PROG_FULL = DEPTH / 2
) (
  input logic clk,
  input logic rst,
  fifo_singleclock_fwft_multi_if.slave bus
);
  localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_nxt;
    logic [CNTW-1:0]  cnt;
    logic [CNTW-1:0]  cnt_nxt;
    logic [WIDTH-1:0] head;
    logic             sel;
    logic             we;
    logic             re;
    logic             wr_head;
    logic             ovf;
    logic             udf;

    always_comb begin
      sel     = bus.wr_en && (bus.wr_chan == CW'(c));
      we      = sel && (cnt != CNTW'(DEPTH));
      re      = bus.rd_en[c] && (cnt != '0);
      rd_nxt  = re ? inc(rd_ptr) : rd_ptr;
      cnt_nxt = cnt;
      if (we && !re)
        cnt_nxt = cnt + 1'b1;
      else if (re && !we)
        cnt_nxt = cnt - 1'b1;
      // incoming word becomes the head: bypass the array
      wr_head = (cnt == '0) ||
                (re && (cnt == CNTW'(1)));
    end

    always_ff @(posedge clk) begin
      if (we)
        mem[wr_ptr] <= bus.din;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
        head   <= '0;
        ovf    <= 1'b0;
        udf    <= 1'b0;
      end else begin
        if (we)
          wr_ptr <= inc(wr_ptr);
        rd_ptr <= rd_nxt;
        cnt    <= cnt_nxt;
        if (cnt_nxt != '0)
          head <= wr_head ? bus.din : mem[rd_nxt];
        if (sel && (cnt == CNTW'(DEPTH)))
          ovf <= 1'b1;
        if (bus.rd_en[c] && (cnt == '0))
          udf <= 1'b1;
      end
    end

    assign bus.full[c]      = (cnt == CNTW'(DEPTH));
    assign bus.prog_full[c] = (cnt >= CNTW'(PROG_FULL));
    assign bus.empty[c]     = (cnt == '0);
    assign bus.overflow[c]  = ovf;
    assign bus.underflow[c] = udf;
    assign bus.fill[c*CNTW +: CNTW]   = cnt;
    assign bus.dout[c*WIDTH +: WIDTH] = head;
  end
endmodule

// File: tb/tb_fifo_singleclock_fwft_multi.sv
// Randomised scoreboard bench for the FWFT FIFO bank,
// checked against a queue-based reference model.
module tb_fifo_singleclock_fwft_multi;
  localparam int W    = 8;
  localparam int D    = 3;
  localparam int CH   = 3;
  localparam int PF   = 2;
  localparam int CW   = 2;
  localparam int CNTW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_singleclock_fwft_multi_if #(
    .WIDTH(W), .DEPTH(D), .CHANNELS(CH)
  ) bus ();

  fifo_singleclock_fwft_multi #(
    .WIDTH(W), .DEPTH(D),
    .CHANNELS(CH), .PROG_FULL(PF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  logic [W-1:0] q [CH][$];
  bit           m_ovf [CH];
  bit           m_udf [CH];
  logic [W-1:0] m_dout [CH];

  int checks   = 0;
  int failures = 0;
  bit mon_on   = 1'b0;

  task automatic chk(input string name, input int c,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s ch%0d at %0t: got %0h expected %0h",
               name, c, $time, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit we,
                      input int ch, input logic [W-1:0] d,
                      input logic [CH-1:0] re);
    bit wa, ra;
    @(negedge clk);
    rst         = r;
    bus.wr_en   = we;
    bus.wr_chan = CW'(ch);
    bus.din     = d;
    bus.rd_en   = re;
    for (int c = 0; c < CH; c++) begin
      if (r) begin
        q[c].delete();
        m_ovf[c]  = 1'b0;
        m_udf[c]  = 1'b0;
        m_dout[c] = '0;
      end else begin
        wa = we && (ch == c) && (q[c].size() < D);
        ra = re[c] && (q[c].size() > 0);
        if (we && (ch == c) && !wa) m_ovf[c] = 1'b1;
        if (re[c] && q[c].size() == 0) m_udf[c] = 1'b1;
        if (ra) void'(q[c].pop_front());
        if (wa) q[c].push_back(d);
        if (q[c].size() > 0) m_dout[c] = q[c][0];
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, '0, '0);
  endtask

  task automatic wr(input int ch, input logic [W-1:0] d);
    step(1'b0, 1'b1, ch, d, '0);
  endtask

  task automatic rd(input logic [CH-1:0] re);
    step(1'b0, 1'b0, 0, '0, re);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_on) begin
        for (int c = 0; c < CH; c++) begin
          int sz;
          sz = q[c].size();
          chk("empty", c, int'(bus.empty[c]), int'(sz == 0));
          chk("full", c, int'(bus.full[c]), int'(sz == D));
          chk("prog_full", c, int'(bus.prog_full[c]),
              int'(sz >= PF));
          chk("fill", c, int'(bus.fill[c*CNTW +: CNTW]), sz);
          chk("overflow", c, int'(bus.overflow[c]),
              int'(m_ovf[c]));
          chk("underflow", c, int'(bus.underflow[c]),
              int'(m_udf[c]));
          chk("dout", c, int'(bus.dout[c*W +: W]),
              int'(m_dout[c]));
        end
      end
    end
  end

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_chan = '0;
    bus.din     = '0;
    bus.rd_en   = '0;
    step(1'b1, 1'b0, 0, '0, '0);
    mon_on = 1'b1;
    step(1'b1, 1'b0, 0, '0, '0);
    idle();

    wr(1, 8'hA1);
    idle();

    for (int i = 0; i < D; i++) wr(0, 8'(8'h10 + i));
    wr(0, 8'h13);
    for (int i = 0; i < D; i++) rd(3'b001);
    idle();

    wr(2, 8'h20);
    for (int i = 1; i <= 10; i++)
      step(1'b0, 1'b1, 2, 8'(8'h20 + i), 3'b100);
    rd(3'b100);
    rd(3'b100);

    for (int i = 0; i < D; i++) wr(0, 8'(8'h40 + i));
    step(1'b0, 1'b1, 0, 8'h55, 3'b001);
    rd(3'b010);
    step(1'b0, 1'b1, 1, 8'h66, 3'b010);
    idle();
    step(1'b0, 1'b1, 1, 8'h67, 3'b010);
    idle();

    wr(2, 8'h77);
    wr(1, 8'h78);
    step(1'b1, 1'b0, 0, '0, '0);
    idle();
    for (int i = 0; i < 4; i++) wr(3, 8'(8'h90 + i));
    idle();

    for (int n = 0; n < 600; n++) begin
      bit r, we;
      int ch;
      logic [CH-1:0] re;
      r  = ($urandom_range(0, 99) == 0);
      we = ($urandom_range(0, 3) != 0);
      ch = $urandom_range(0, 3);
      re = CH'($urandom) & CH'($urandom | $urandom);
      step(r, we, ch, W'($urandom), re);
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_singleclock_fwft_multi.md
Name: fifo_singleclock_fwft_multi

Overview:
Single-clock first-word fall-through FIFO bank with CHANNELS independent queues behind one shared write port. Each channel has its own FWFT read port, fill level, programmable-full flag and sticky error flags. Storage is self-contained register/array state, with no wrapped standard FIFO. Used as a per-virtual-channel ingress buffer in NoC adapters and DMA engines.

Parameters:
WIDTH, 8, data word width in bits.
DEPTH, 32, entries per channel; any value >= 2, power of two not required.
CHANNELS, 2, number of independent queues; >= 1.
PROG_FULL, DEPTH/2, prog_full[c] asserted when fill[c] >= PROG_FULL; range 1..DEPTH.
Derived: CW = max(1, clog2(CHANNELS)); CNTW = clog2(DEPTH+1).

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
din  in  WIDTH  write data.
wr_chan  in  CW  target channel for the write.
wr_en  in  1  write strobe.
full  out  CHANNELS  full[c] = (fill[c] == DEPTH).
prog_full  out  CHANNELS  fill[c] >= PROG_FULL.
dout  out  CHANNELS*WIDTH  head word of channel c on bits [c*WIDTH +: WIDTH].
rd_en  in  CHANNELS  pop head of channel c.
empty  out  CHANNELS  empty[c] = (fill[c] == 0).
fill  out  CHANNELS*CNTW  occupancy of channel c on bits [c*CNTW +: CNTW].
overflow  out  CHANNELS  sticky: write attempted to a full channel.
underflow  out  CHANNELS  sticky: read attempted on an empty channel.

Behaviour:
- Reset (synchronous, rst high at clk edge):
  - all read/write pointers and fill counters = 0.
  - empty = all ones; full, prog_full, overflow, underflow = 0.
  - dout = 0.
  - Storage contents are not reset.
  - Reset mid-operation discards all queued data immediately; the next cycle shows empty.
- Per-channel state:
  - wr_ptr and rd_ptr in 0..DEPTH-1. A pointer at DEPTH-1 wraps to 0 explicitly; modulo-2^n wrap is not permitted.
  - fill counter in 0..DEPTH; all flags derive from the registered fill.
- Write (accepted when wr_en && wr_chan < CHANNELS && !full[wr_chan]):
  - din stored at wr_ptr; wr_ptr advances; fill increments.
  - wr_chan >= CHANNELS: write silently dropped, no flag change.
  - wr_en to a full channel: write dropped, overflow[wr_chan] set; state otherwise unchanged.
- Read (rd_en[c] && !empty[c]): rd_ptr advances; fill decrements.
  - rd_en[c] while empty[c]: ignored, underflow[c] set.
  - Reads on several channels in the same cycle are independent.
- FWFT output:
  - dout[c] is always the word at the head of channel c whenever empty[c] = 0; no rd_en is needed to present it.
  - Write latency: a word written into an empty channel at edge N gives empty[c] = 0 and valid dout[c] after edge N, i.e. usable in cycle N+1.
  - Read latency: after a pop at edge N, the next word appears on dout[c] in cycle N+1.
  - dout[c] holds its last value while empty; consumers must not rely on it.
  - dout is registered, with no combinational path from rd_en/wr_en to dout.
- Simultaneous read and write, same channel:
  - 0 < fill < DEPTH: both occur, fill unchanged.
  - fill == 0: write accepted, read ignored, underflow set; the word appears next cycle.
  - fill == DEPTH: full is evaluated before the read, so the write is dropped, overflow set, and the read proceeds; fill becomes DEPTH-1.
  - fill == 1 with read + write: the new word is presented on dout in the next cycle.
- Flags are registered/derived from the registered fill, with no combinational path from inputs.
- overflow and underflow clear only on rst.

Test Plan:
- Reset, then idle → empty = all ones, full = 0, fill = 0, overflow = underflow = 0, dout = 0.
- CHANNELS=2, DEPTH=4: write 0xA1 to ch1 at edge N, rd_en = 0 → cycle N+1: empty[1] = 0, dout[1] = 0xA1, fill[1] = 1; ch0 stays empty.
- Fill ch0 with 0x10..0x13 → full[0] = 1, prog_full[0] = 1 from fill = 2. Write 0x14 → dropped, overflow[0] = 1. Pop 4 times → 0x10, 0x11, 0x12, 0x13 in order; empty[0] = 1.
- Wrap: DEPTH=3, push/pop 10 words continuously with write and read in the same cycle at fill = 1 → every word emerges in order, fill stays 1, no flags set.
- Full + simultaneous rd/wr on ch0 (fill = 4): 0x55 dropped, overflow[0] = 1, fill[0] = 3, head advances. Empty + rd/wr: 0x66 accepted, underflow set, dout = 0x66 next cycle.
- Assert rst with both channels half full → next cycle all empty, fill = 0, sticky flags cleared; wr_chan = 2 with CHANNELS = 2 → no state change.
